// File: rtl/regfile_ctx_engine.sv
// Context save/restore master for the 32x32 regfile sbus ports (ALU read port untouched).
// Latency: first save beat one cycle after start; regfile write one cycle after each restore handshake.
// Backpressure: so_valid holds with stable data until so_ready; si_ready high throughout RESTORE.
//
// Ports:
//   clk_i, reset_n_i                   clock (rising edge), asynchronous active-low reset
//   start_i, mode_i, abort_i           command: start (IDLE only), 0=SAVE/1=RESTORE, cancel
//   busy_o, done_o                     status: busy in SAVE/RESTORE/DONE, one-cycle done pulse
//   rf_sbus_select_o, rf_sbus_out_i    regfile read select / combinational read data
//   rf_write_select_o, rf_sbus_in_o    regfile write select (0 = no write) / write data
//   so_data_o, so_valid_o, so_ready_i  save stream (valid/ready)
//   si_data_i, si_valid_i, si_ready_o  restore stream (valid/ready)
module regfile_ctx_engine #(
    parameter int DATA_W    = 32,
    parameter int SEL_W     = 5,
    parameter int FIRST_REG = 1,
    parameter int LAST_REG  = 31
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [SEL_W-1:0]  rf_sbus_select_o,
    input  logic [DATA_W-1:0] rf_sbus_out_i,
    output logic [SEL_W-1:0]  rf_write_select_o,
    output logic [DATA_W-1:0] rf_sbus_in_o,
    output logic [DATA_W-1:0] so_data_o,
    output logic              so_valid_o,
    input  logic              so_ready_i,
    input  logic [DATA_W-1:0] si_data_i,
    input  logic              si_valid_i,
    output logic              si_ready_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAVE,
        ST_RESTORE,
        ST_DONE
    } state_e;

    localparam logic [SEL_W-1:0] FIRST_SEL = SEL_W'(FIRST_REG);
    localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(LAST_REG);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic [SEL_W-1:0]    wsel_q, wsel_d;
    logic [DATA_W-1:0]   wdat_q, wdat_d;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            wsel_q  <= '0;
            wdat_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wsel_q  <= wsel_d;
            wdat_q  <= wdat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        // Write pulse lasts exactly one cycle unless re-armed by another handshake.
        wsel_d  = '0;
        wdat_d  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    idx_d   = FIRST_SEL;
                    state_d = mode_i ? ST_RESTORE : ST_SAVE;
                end
            end
            ST_SAVE: begin
                // so_valid is constantly high here, so ready alone completes the beat.
                if (so_ready_i) begin
                    if (idx_q == LAST_SEL) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + SEL_W'(1);
                    end
                end
            end
            ST_RESTORE: begin
                if (si_valid_i) begin
                    wsel_d = idx_q;
                    wdat_d = si_data_i;
                    if (idx_q == LAST_SEL) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + SEL_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
        // Abort overrides everything, including a handshake in the same cycle.
        if (abort_i) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            wsel_d  = '0;
            wdat_d  = '0;
        end
    end

    assign busy_o            = (state_q != ST_IDLE);
    assign done_o            = (state_q == ST_DONE) && !abort_i;
    assign rf_sbus_select_o  = (state_q == ST_SAVE) ? idx_q : '0;
    assign so_valid_o        = (state_q == ST_SAVE);
    // Gate read data so the stream is quiet outside SAVE.
    assign so_data_o         = (state_q == ST_SAVE) ? rf_sbus_out_i : '0;
    assign si_ready_o        = (state_q == ST_RESTORE);
    assign rf_write_select_o = wsel_q;
    assign rf_sbus_in_o      = wdat_q;

endmodule

// File: tb/tb_regfile_ctx_engine.sv
module tb_regfile_ctx_engine;
    localparam int DW    = 32;
    localparam int SW    = 5;
    localparam int FIRST = 1;
    localparam int LAST  = 31;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start, mode, abort_s;
    logic          busy, done;
    logic [SW-1:0] rf_sbus_select, rf_write_select;
    logic [DW-1:0] rf_sbus_out, rf_sbus_in;
    logic [DW-1:0] so_data, si_data;
    logic          so_valid, so_ready, si_valid, si_ready;

    always #5 clk = ~clk;

    regfile_ctx_engine #(.DATA_W(DW), .SEL_W(SW), .FIRST_REG(FIRST), .LAST_REG(LAST)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .start_i(start), .mode_i(mode), .abort_i(abort_s),
        .busy_o(busy), .done_o(done),
        .rf_sbus_select_o(rf_sbus_select), .rf_sbus_out_i(rf_sbus_out),
        .rf_write_select_o(rf_write_select), .rf_sbus_in_o(rf_sbus_in),
        .so_data_o(so_data), .so_valid_o(so_valid), .so_ready_i(so_ready),
        .si_data_i(si_data), .si_valid_i(si_valid), .si_ready_o(si_ready)
    );

    // Regfile environment model: combinational read, write on select != 0.
    logic [DW-1:0] rf [32];
    logic          pre_en = 1'b0;
    logic [DW-1:0] pre_base = '0;
    assign rf_sbus_out = rf[rf_sbus_select];
    always @(posedge clk) begin
        if (pre_en) begin
            for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? '0 : pre_base + 32'(i);
        end else if (rf_write_select != '0) begin
            rf[rf_write_select] <= rf_sbus_in;
        end
    end

    typedef struct packed {
        logic [SW-1:0] sel;
        logic [DW-1:0] dat;
    } beat_t;
    beat_t so_q[$];
    beat_t wr_q[$];

    typedef struct {
        logic start, mode, abort_v, rdy;
        logic e_busy, e_valid, e_si_rdy;
        logic [SW-1:0] e_sel;
        logic [DW-1:0] e_data;
    } vec_t;
    vec_t tbl[9];

    int checks = 0;
    int errors = 0;
    bit sb_en = 1'b0;
    logic          prev_valid = 1'b0, prev_hs = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [SW-1:0] prev_sel = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event missing expected event seen", name);
    endtask

    // Per-cycle scoreboard/monitor, called at the negedge.
    task automatic mon();
        beat_t b;
        logic  hs;
        if (!sb_en) return;
        if (so_valid && prev_valid && !prev_hs) begin
            check("so_data_hold", so_data, prev_data);
            check("so_sel_hold", 32'(rf_sbus_select), 32'(prev_sel));
        end
        hs = so_valid && so_ready && !abort_s;
        if (hs) begin
            if (so_q.size() == 0) fail_now("so_extra_beat");
            else begin
                b = so_q.pop_front();
                check("so_beat_sel", 32'(rf_sbus_select), 32'(b.sel));
                check("so_beat_data", so_data, b.dat);
            end
        end
        prev_valid = so_valid;
        prev_hs    = hs;
        prev_data  = so_data;
        prev_sel   = rf_sbus_select;
        if (rf_write_select != '0) begin
            if (wr_q.size() == 0) fail_now("rf_extra_write");
            else begin
                b = wr_q.pop_front();
                check("wr_sel", 32'(rf_write_select), 32'(b.sel));
                check("wr_data", rf_sbus_in, b.dat);
            end
        end
    endtask

    task automatic preload(input logic [DW-1:0] base);
        @(posedge clk); #1;
        pre_base = base;
        pre_en   = 1'b1;
        @(posedge clk); #1;
        pre_en   = 1'b0;
    endtask

    task automatic run_save(input logic [3:0] pat, input logic [DW-1:0] base);
        int c, last_hs;
        bit seen;
        for (int n = FIRST; n <= LAST; n++) so_q.push_back('{sel: SW'(n), dat: base + 32'(n)});
        seen = 1'b0;
        last_hs = -10;
        for (c = 0; c < 400 && !seen; c++) begin
            @(posedge clk); #1;
            start    = (c == 0);
            mode     = 1'b0;
            so_ready = pat[2'(c % 4)];
            @(negedge clk);
            if (c == 0) check("save_lat_idle_valid", 32'(so_valid), 32'd0);
            if (c == 1) begin
                check("save_lat_first_valid", 32'(so_valid), 32'd1);
                check("save_first_sel", 32'(rf_sbus_select), 32'(FIRST));
            end
            if (so_valid && so_ready) last_hs = c;
            if (done) begin
                seen = 1'b1;
                check("save_done_after_last", 32'(c), 32'(last_hs + 1));
                check("save_done_busy", 32'(busy), 32'd1);
            end
            mon();
        end
        if (!seen) fail_now("save_done_timeout");
        check("save_words_left", 32'(so_q.size()), 32'd0);
        @(posedge clk); #1;
        so_ready = 1'b0;
        @(negedge clk);
        mon();
        check("save_idle_busy", 32'(busy), 32'd0);
        check("save_done_one_cycle", 32'(done), 32'd0);
    endtask

    task automatic run_restore(input logic [DW-1:0] base, input int abort_at);
        int c, k, last_n;
        bit seen, ab_done;
        last_n = (abort_at != 0) ? FIRST + abort_at - 1 : LAST;
        for (int n = FIRST; n <= last_n; n++) wr_q.push_back('{sel: SW'(n), dat: base + 32'(n)});
        k = 0;
        seen = 1'b0;
        ab_done = 1'b0;
        for (c = 0; c < 400 && !seen && !ab_done; c++) begin
            @(posedge clk); #1;
            start    = (c == 0);
            mode     = 1'b1;
            si_valid = 1'b1;
            si_data  = base + 32'(FIRST + k);
            abort_s  = (abort_at != 0) && (k == abort_at);
            @(negedge clk);
            mon();
            if (abort_s) ab_done = 1'b1;
            if (si_valid && si_ready && !abort_s) k++;
            if (done) begin
                seen = 1'b1;
                check("restore_done_last_write", 32'(rf_write_select), 32'(LAST));
                check("restore_done_busy", 32'(busy), 32'd1);
            end
        end
        if (abort_at == 0 && !seen) fail_now("restore_done_timeout");
        if (abort_at != 0) check("restore_abort_no_done", 32'(seen), 32'd0);
        @(posedge clk); #1;
        start    = 1'b0;
        abort_s  = 1'b0;
        si_valid = 1'b0;
        @(negedge clk);
        mon();
        check("restore_end_busy", 32'(busy), 32'd0);
        check("restore_end_wsel", 32'(rf_write_select), 32'd0);
        check("restore_end_si_ready", 32'(si_ready), 32'd0);
        check("restore_writes_left", 32'(wr_q.size()), 32'd0);
    endtask

    initial begin
        int  c;
        bit  hit;
        // start mode abort rdy | busy valid si_rdy sel data
        tbl[0] = '{1, 0, 1, 0, 0, 0, 0, 5'd0, 32'h0};
        tbl[1] = '{0, 0, 0, 0, 0, 0, 0, 5'd0, 32'h0};
        tbl[2] = '{1, 0, 0, 0, 0, 0, 0, 5'd0, 32'h0};
        tbl[3] = '{0, 0, 0, 0, 1, 1, 0, 5'd1, 32'hA000_0001};
        tbl[4] = '{1, 1, 0, 0, 1, 1, 0, 5'd1, 32'hA000_0001};
        tbl[5] = '{0, 0, 0, 1, 1, 1, 0, 5'd1, 32'hA000_0001};
        tbl[6] = '{0, 0, 0, 0, 1, 1, 0, 5'd2, 32'hA000_0002};
        tbl[7] = '{0, 0, 1, 1, 1, 1, 0, 5'd2, 32'hA000_0002};
        tbl[8] = '{0, 0, 0, 0, 0, 0, 0, 5'd0, 32'h0};

        reset_n = 1'b0; start = 1'b0; mode = 1'b0; abort_s = 1'b0;
        so_ready = 1'b0; si_valid = 1'b0; si_data = '0;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sel", 32'(rf_sbus_select), 32'd0);
        check("rst_wsel", 32'(rf_write_select), 32'd0);
        check("rst_wdata", rf_sbus_in, 32'd0);
        check("rst_so_valid", 32'(so_valid), 32'd0);
        check("rst_so_data", so_data, 32'd0);
        check("rst_si_ready", 32'(si_ready), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        preload(32'hA000_0000);

        // start&abort in IDLE, start during SAVE, abort discarding a handshake.
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            start = tbl[i].start; mode = tbl[i].mode;
            abort_s = tbl[i].abort_v; so_ready = tbl[i].rdy;
            @(negedge clk);
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            check($sformatf("tbl%0d_so_valid", i), 32'(so_valid), 32'(tbl[i].e_valid));
            check($sformatf("tbl%0d_si_ready", i), 32'(si_ready), 32'(tbl[i].e_si_rdy));
            check($sformatf("tbl%0d_sel", i), 32'(rf_sbus_select), 32'(tbl[i].e_sel));
            check($sformatf("tbl%0d_data", i), so_data, tbl[i].e_data);
        end

        sb_en = 1'b1;
        run_save(4'b1111, 32'hA000_0000);
        run_save(4'b1001, 32'hA000_0000);
        run_restore(32'h5000_0000, 0);
        run_save(4'b1111, 32'h5000_0000);

        preload(32'hA000_0000);
        run_restore(32'h6000_0000, 10);
        for (int n = 1; n <= 31; n++)
            check($sformatf("abort_rf%0d", n), rf[n],
                  (n <= 10) ? 32'h6000_0000 + 32'(n) : 32'hA000_0000 + 32'(n));

        // Reset mid-RESTORE while the write to r3 is pending.
        sb_en = 1'b0;
        hit = 1'b0;
        for (c = 0; c < 50 && !hit; c++) begin
            @(posedge clk); #1;
            start = (c == 0); mode = 1'b1; si_valid = 1'b1;
            si_data = 32'h7000_0000 + 32'(c);
            @(negedge clk);
            if (rf_write_select == 5'd3) hit = 1'b1;
        end
        if (!hit) fail_now("reset_pending_write_timeout");
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_wsel", 32'(rf_write_select), 32'd0);
        check("midrst_wdata", rf_sbus_in, 32'd0);
        check("midrst_si_ready", 32'(si_ready), 32'd0);
        check("midrst_so_valid", 32'(so_valid), 32'd0);
        @(posedge clk); #1;
        check("midrst_no_write_r3", rf[3], 32'h6000_0003);
        reset_n = 1'b1; start = 1'b0; si_valid = 1'b0;
        @(negedge clk);
        check("postrst_busy", 32'(busy), 32'd0);
        check("postrst_si_ready", 32'(si_ready), 32'd0);

        check("final_so_q", 32'(so_q.size()), 32'd0);
        check("final_wr_q", 32'(wr_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
